// File: rtl/connect_four_buttons_pkg.sv
// Shared types and default 25 MHz timing for the Connect Four button front end.
package connect_four_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } move_state_t;

  localparam int DEBOUNCE_CYCLES_25M = 250_000;
  localparam int REPEAT_DELAY_25M    = 12_500_000;
  localparam int REPEAT_RATE_25M     = 3_125_000;
  localparam int CNT_W_DEFAULT       = 24;

endpackage

// File: rtl/connect_four_buttons_if.sv
// Raw button inputs and conditioned command pulses between the board and the game core.
interface connect_four_buttons_if;
  logic btn_right;
  logic btn_left;
  logic btn_drop;
  logic move_right;
  logic move_left;
  logic drop_piece;

  modport master (output btn_right, btn_left, btn_drop,
                  input  move_right, move_left, drop_piece);
  modport slave  (input  btn_right, btn_left, btn_drop,
                  output move_right, move_left, drop_piece);
endinterface

// File: rtl/connect_four_buttons_debounce.sv
// One button: 2-flop synchronizer, mismatch-count debounce, stable level and press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Final mismatch sample of a full run: commit the new level this cycle.
  assign accept = (sync2_q != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (accept) begin
      stable_d = sync2_q;
      rise_d   = sync2_q;
    end else if (sync2_q != stable_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/connect_four_buttons.sv
// Button front end: debounces three buttons, auto-repeats left/right, emits one command pulse per clock.
module connect_four_buttons
  import connect_four_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25M,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_25M,
  parameter int REPEAT_RATE     = REPEAT_RATE_25M,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                   clk_25MHz,
  input  logic                   rst_n,
  connect_four_buttons_if.slave  bus
);

  logic stab_r, stab_l, stab_d;
  logic rise_r, rise_l, rise_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
    .clk(clk_25MHz), .rst_n(rst_n), .btn_i(bus.btn_right), .stable_o(stab_r), .rise_o(rise_r));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
    .clk(clk_25MHz), .rst_n(rst_n), .btn_i(bus.btn_left), .stable_o(stab_l), .rise_o(rise_l));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_drop (
    .clk(clk_25MHz), .rst_n(rst_n), .btn_i(bus.btn_drop), .stable_o(stab_d), .rise_o(rise_d));

  move_state_t      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             dir_left_q, dir_left_d;
  logic             pending_q, pending_d;
  logic             move_right_q, move_left_q, drop_piece_q;
  logic             mv_r, mv_l, drop_out;
  logic             held, other, drop_req;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dir_left_d = dir_left_q;
    mv_r       = 1'b0;
    mv_l       = 1'b0;
    held       = dir_left_q ? stab_l : stab_r;
    other      = dir_left_q ? stab_r : stab_l;
    case (state_q)
      IDLE: begin
        if (stab_l && stab_r) begin
          state_d = LOCK;
        end else if (rise_l || rise_r) begin
          mv_l       = rise_l;
          mv_r       = rise_r;
          dir_left_d = rise_l;
          timer_d    = CNT_W'(REPEAT_DELAY);
          state_d    = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!held) begin
          state_d = IDLE;
        end else if (other) begin
          state_d = LOCK;
        end else if (timer_q == CNT_W'(1)) begin
          mv_l    = dir_left_q;
          mv_r    = !dir_left_q;
          timer_d = CNT_W'(REPEAT_RATE);
          state_d = REPEAT;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      LOCK: begin
        if (!stab_l && !stab_r) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A move wins the cycle; a colliding drop waits one clock in the pending flag.
    drop_req  = rise_d || pending_q;
    pending_d = (mv_l || mv_r) && drop_req;
    drop_out  = !(mv_l || mv_r) && drop_req;
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      dir_left_q   <= 1'b0;
      pending_q    <= 1'b0;
      move_right_q <= 1'b0;
      move_left_q  <= 1'b0;
      drop_piece_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dir_left_q   <= dir_left_d;
      pending_q    <= pending_d;
      move_right_q <= mv_r;
      move_left_q  <= mv_l;
      drop_piece_q <= drop_out;
    end
  end

  assign bus.move_right = move_right_q;
  assign bus.move_left  = move_left_q;
  assign bus.drop_piece = drop_piece_q;

endmodule

// File: tb/tb_connect_four_buttons.sv
// Scoreboard bench for connect_four_buttons with short debounce/repeat timing.
module tb_connect_four_buttons;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int LAT = DB + 3;

  localparam logic [2:0] C_RIGHT = 3'b001;
  localparam logic [2:0] C_LEFT  = 3'b010;
  localparam logic [2:0] C_DROP  = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  connect_four_buttons_if bus_if ();

  connect_four_buttons #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(24)
  ) dut (
    .clk_25MHz(clk),
    .rst_n(rst_n),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(input int c, input logic [2:0] code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every observed pulse must match the head of the queue in cycle and kind.
  always @(negedge clk) begin
    logic [2:0] obs;
    exp_t e;
    obs = {bus_if.drop_piece, bus_if.move_left, bus_if.move_right};
    if (rst_n) begin
      if (obs != 3'b000) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, obs);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.code != obs) begin
            errors++;
            $display("FAIL pulse cyc=%0d got=%b want=%b@%0d", cyc, obs, e.code, e.cyc);
          end
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missed_pulse cyc=%0d got=000 want=%b@%0d", cyc, e.code, e.cyc);
      end
    end
  end

  task automatic check_zero(input string name);
    logic [2:0] obs;
    obs = {bus_if.drop_piece, bus_if.move_left, bus_if.move_right};
    checks++;
    if (obs != 3'b000) begin
      errors++;
      $display("FAIL %s got=%b want=000", name, obs);
    end
  endtask

  initial begin
    int d;
    bus_if.btn_right = 1'b0;
    bus_if.btn_left  = 1'b0;
    bus_if.btn_drop  = 1'b0;
    tick(3);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    tick(5);

    // 1: bouncy drop, then held
    d = cyc;
    for (int i = 0; i < 5; i++) begin
      bus_if.btn_drop = (i % 2 == 0);
      tick(2);
    end
    expect_at(d + 8 + LAT, C_DROP);
    tick(20);
    bus_if.btn_drop = 1'b0;
    tick(15);

    // 2: left held with auto-repeat
    d = cyc;
    bus_if.btn_left = 1'b1;
    expect_at(d + LAT, C_LEFT);
    for (int k = 0; k < 5; k++) expect_at(d + LAT + RD + k * RR, C_LEFT);
    tick(LAT + 50);
    bus_if.btn_left = 1'b0;
    tick(40);

    // 3: left+right together lock out, then right alone
    bus_if.btn_left  = 1'b1;
    bus_if.btn_right = 1'b1;
    tick(40);
    bus_if.btn_left  = 1'b0;
    bus_if.btn_right = 1'b0;
    tick(15);
    d = cyc;
    bus_if.btn_right = 1'b1;
    expect_at(d + LAT, C_RIGHT);
    tick(10);
    bus_if.btn_right = 1'b0;
    tick(15);

    // 4: right and drop collide
    d = cyc;
    bus_if.btn_right = 1'b1;
    bus_if.btn_drop  = 1'b1;
    expect_at(d + LAT, C_RIGHT);
    expect_at(d + LAT + 1, C_DROP);
    tick(10);
    bus_if.btn_right = 1'b0;
    bus_if.btn_drop  = 1'b0;
    tick(15);

    // 5: reset during DELAY with right held
    d = cyc;
    bus_if.btn_right = 1'b1;
    expect_at(d + LAT, C_RIGHT);
    tick(LAT + 5);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_delay");
    tick(3);
    check_zero("reset_held");
    d = cyc;
    rst_n = 1'b1;
    expect_at(d + LAT, C_RIGHT);
    tick(10);
    bus_if.btn_right = 1'b0;
    tick(15);

    // 6: short glitch on left
    bus_if.btn_left = 1'b1;
    tick(3);
    bus_if.btn_left = 1'b0;
    tick(20);

    tick(10);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL never_seen want=%b@%0d", e.code, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
